// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
//   Shared definitions for the integer register file slice of the RISC-V core.
//   XLEN      : architectural register width
//   NUM_REGS  : number of architectural integer registers
//   dump_state_e : states of the register dump engine
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [0:0] {
        DUMP_IDLE = 1'b0,
        DUMP_SEND = 1'b1
    } dump_state_e;

endpackage : rv_pkg

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Per-register busy vector tracking outstanding multi-cycle producers.
//   A register is marked busy when a producer targeting it issues, and is
//   cleared when writeback lands on it. Issue and writeback to the same index
//   in the same cycle leave it busy: the newer producer still owes a value.
//   Ports:
//     clk, reset        clock, asynchronous active-low reset
//     we, waddr         writeback enable / destination (clears busy)
//     iss_valid, iss_rd producer issue / destination (sets busy)
//     raddr0, raddr1    read port source selects
//     rbusy0, rbusy1    hazard flags for the two read ports
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter  int DEPTH    = NUM_REGS,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    output logic          rbusy0,
    output logic          rbusy1
);

    localparam logic ZR = (ZERO_REG != 0) ? 1'b1 : 1'b0;

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic             rbusy0_s;
    logic             rbusy1_s;

    // Next busy vector: issue (set) has priority over writeback (clear).
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (ZR && (i == 0)) begin
                busy_nxt_s[i] = 1'b0;
            end else if (iss_valid && (iss_rd == AW'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (we && (waddr == AW'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Busy vector storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Hazard lookup: a write landing this cycle is bypassed, so it is not a hazard.
    always_comb begin
        if (ZR && (raddr0 == '0)) begin
            rbusy0_s = 1'b0;
        end else if (we && (waddr == raddr0)) begin
            rbusy0_s = 1'b0;
        end else begin
            rbusy0_s = busy_r[raddr0];
        end
        if (ZR && (raddr1 == '0)) begin
            rbusy1_s = 1'b0;
        end else if (we && (waddr == raddr1)) begin
            rbusy1_s = 1'b0;
        end else begin
            rbusy1_s = busy_r[raddr1];
        end
    end

    assign rbusy0 = rbusy0_s;
    assign rbusy1 = rbusy1_s;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb_dump.sv
// ---------------------------------------------------------------------------
// regfile_sb_dump
//   Parametrised integer register file with write-to-read bypass, optional
//   hardwired zero register, busy scoreboard and a debug dump engine.
//   Ports:
//     clk, reset              clock, asynchronous active-low reset
//     we, waddr, wdata        writeback port
//     raddr0/1, rdata0/1      combinational bypassed read ports
//     rbusy0/1                outstanding-producer hazard flags
//     iss_valid, iss_rd       multi-cycle producer issue
//     dump_start              pulse: stream all registers
//     dump_valid/ready        dump beat handshake
//     dump_idx, dump_data     index and current contents of the dump beat
//     dump_last               beat is index DEPTH-1
//     dump_active             dump engine busy
// ---------------------------------------------------------------------------
module regfile_sb_dump
    import rv_pkg::*;
#(
    parameter  int WIDTH    = XLEN,
    parameter  int DEPTH    = NUM_REGS,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             rbusy0,
    output logic             rbusy1,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             dump_start,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [AW-1:0]    dump_idx,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_last,
    output logic             dump_active
);

    localparam logic ZR = (ZERO_REG != 0) ? 1'b1 : 1'b0;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_en_s;
    logic [WIDTH-1:0] rdata0_s;
    logic [WIDTH-1:0] rdata1_s;
    logic [WIDTH-1:0] dump_data_s;

    dump_state_e      state_r;
    logic [AW-1:0]    dump_idx_r;
    logic             dump_valid_r;
    logic             dump_last_r;
    logic             dump_active_r;

    // Write qualification: register 0 is read-only when hardwired to zero.
    always_comb begin
        if (ZR && (waddr == '0)) begin
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = we;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read ports: zero register first, then same-cycle writeback bypass, then storage.
    always_comb begin
        if (ZR && (raddr0 == '0)) begin
            rdata0_s = '0;
        end else if (we && (waddr == raddr0)) begin
            rdata0_s = wdata;
        end else begin
            rdata0_s = mem_r[raddr0];
        end
        if (ZR && (raddr1 == '0)) begin
            rdata1_s = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1_s = wdata;
        end else begin
            rdata1_s = mem_r[raddr1];
        end
    end

    // Dump data is raw storage (no bypass) so a beat reflects the value held in the accept cycle.
    always_comb begin
        if (ZR && (dump_idx_r == '0)) begin
            dump_data_s = '0;
        end else begin
            dump_data_s = mem_r[dump_idx_r];
        end
    end

    // Dump engine: walks indices 0..DEPTH-1 once per start, advancing on each accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= DUMP_IDLE;
            dump_idx_r    <= '0;
            dump_valid_r  <= 1'b0;
            dump_last_r   <= 1'b0;
            dump_active_r <= 1'b0;
        end else begin
            case (state_r)
                DUMP_IDLE: begin
                    if (dump_start) begin
                        state_r       <= DUMP_SEND;
                        dump_idx_r    <= '0;
                        dump_valid_r  <= 1'b1;
                        dump_last_r   <= 1'b0;
                        dump_active_r <= 1'b1;
                    end
                end
                DUMP_SEND: begin
                    if (dump_ready) begin
                        if (dump_last_r) begin
                            state_r       <= DUMP_IDLE;
                            dump_idx_r    <= '0;
                            dump_valid_r  <= 1'b0;
                            dump_last_r   <= 1'b0;
                            dump_active_r <= 1'b0;
                        end else begin
                            dump_idx_r  <= dump_idx_r + AW'(1);
                            // Next index is the final one when the current is DEPTH-2.
                            dump_last_r <= (dump_idx_r == AW'(DEPTH - 2));
                        end
                    end
                end
                default: begin
                    state_r       <= DUMP_IDLE;
                    dump_idx_r    <= '0;
                    dump_valid_r  <= 1'b0;
                    dump_last_r   <= 1'b0;
                    dump_active_r <= 1'b0;
                end
            endcase
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .raddr0    (raddr0),
        .raddr1    (raddr1),
        .rbusy0    (rbusy0),
        .rbusy1    (rbusy1)
    );

    assign rdata0      = rdata0_s;
    assign rdata1      = rdata1_s;
    assign dump_data   = dump_data_s;
    assign dump_valid  = dump_valid_r;
    assign dump_idx    = dump_idx_r;
    assign dump_last   = dump_last_r;
    assign dump_active = dump_active_r;

endmodule : regfile_sb_dump
